// File: rtl/threshold_detector.sv
// Hysteretic threshold detector with debounce and holdoff. Define PEAK_CAPTURE_EN
// to capture the peak sample of each completed ACTIVE interval.
module threshold_detector #(
    parameter int DATA_WD  = 16,
    parameter int DEBOUNCE = 4,
    parameter int HOLDOFF  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic signed [DATA_WD-1:0] i_data,
    input  logic signed [DATA_WD-1:0] i_thr_hi,
    input  logic signed [DATA_WD-1:0] i_thr_lo,
    output logic                      o_event,
    output logic                      o_active,
    output logic [7:0]                o_evt_cnt,
    output logic signed [DATA_WD-1:0] o_peak,
    output logic                      o_peak_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] deb_cnt_r;
    logic [7:0] hold_cnt_r;
    logic       hi_hit_s;
    logic       lo_hit_s;
    logic       trigger_s;
    logic       release_s;
    logic       hold_done_s;

    assign hi_hit_s    = i_valid && (i_data >= i_thr_hi);
    assign lo_hit_s    = i_valid && (i_data <= i_thr_lo);
    assign trigger_s   = (state_r == ST_IDLE) && hi_hit_s && (deb_cnt_r == DEB_LAST);
    assign release_s   = (state_r == ST_ACTIVE) && lo_hit_s;
    assign hold_done_s = (state_r == ST_HOLDOFF) && (hold_cnt_r == HOLD_LAST);

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) state_nxt_s = ST_ACTIVE;
                else           state_nxt_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (release_s) state_nxt_s = ST_HOLDOFF;
                else           state_nxt_s = ST_ACTIVE;
            end
            ST_HOLDOFF: begin
                if (hold_done_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_HOLDOFF;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Debounce streak: only counts in IDLE, frozen on invalid cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst || (state_r != ST_IDLE)) begin
            deb_cnt_r <= 4'd0;
        end else if (i_valid) begin
            if (hi_hit_s && !trigger_s) deb_cnt_r <= deb_cnt_r + 4'd1;
            else                        deb_cnt_r <= 4'd0;
        end else begin
            deb_cnt_r <= deb_cnt_r;
        end
    end

    // Holdoff dwell counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_cnt_r <= 8'd0;
        end else if ((state_r == ST_HOLDOFF) && !hold_done_s) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_r <= 8'd0;
        end
    end

    // Registered event, activity and saturating event count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_event   <= 1'b0;
            o_active  <= 1'b0;
            o_evt_cnt <= 8'd0;
        end else begin
            o_event  <= trigger_s;
            o_active <= (state_nxt_s == ST_ACTIVE);
            if (trigger_s && (o_evt_cnt != 8'hFF)) o_evt_cnt <= o_evt_cnt + 8'd1;
            else                                   o_evt_cnt <= o_evt_cnt;
        end
    end

`ifdef PEAK_CAPTURE_EN
    logic signed [DATA_WD-1:0] run_max_r;
    logic signed [DATA_WD-1:0] max_s;

    // The releasing sample still competes for the peak.
    assign max_s = (i_data > run_max_r) ? i_data : run_max_r;

    // Running maximum during ACTIVE and peak publication on release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_max_r    <= '0;
            o_peak       <= '0;
            o_peak_valid <= 1'b0;
        end else begin
            o_peak_valid <= release_s;
            if (trigger_s) begin
                run_max_r <= i_data;
            end else if ((state_r == ST_ACTIVE) && i_valid) begin
                run_max_r <= max_s;
            end else begin
                run_max_r <= run_max_r;
            end
            if (release_s) o_peak <= max_s;
            else           o_peak <= o_peak;
        end
    end
`else
    assign o_peak       = '0;
    assign o_peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_threshold_detector.sv
// Directed bench for threshold_detector (DEBOUNCE=3, HOLDOFF=4) with a
// cycle-level reference model and hand-computed spot checks.
module tb_threshold_detector;

    localparam int DW   = 16;
    localparam int DEB  = 3;
    localparam int HOLD = 4;

    logic                 clk;
    logic                 rst;
    logic                 valid;
    logic signed [DW-1:0] data;
    logic signed [DW-1:0] thr_hi;
    logic signed [DW-1:0] thr_lo;
    logic                 o_event;
    logic                 o_active;
    logic [7:0]           o_evt_cnt;
    logic signed [DW-1:0] o_peak;
    logic                 o_peak_valid;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    threshold_detector #(.DATA_WD(DW), .DEBOUNCE(DEB), .HOLDOFF(HOLD)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_data       (data),
        .i_thr_hi     (thr_hi),
        .i_thr_lo     (thr_lo),
        .o_event      (o_event),
        .o_active     (o_active),
        .o_evt_cnt    (o_evt_cnt),
        .o_peak       (o_peak),
        .o_peak_valid (o_peak_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 active, 2 holdoff.
    typedef struct {
        int mode;
        int streak;
        int hold_left;
        int evts;
        int runmax;
        int ev;
        int act;
        int peak;
        int pv;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t model_next(model_t c, bit r, bit v, int d, int hi, int lo);
        model_t n = c;
        n.ev = 0;
        n.pv = 0;
        if (r) begin
            n = '{default: 0};
        end else if (c.mode == 0) begin
            if (v && d >= hi) begin
                n.streak = c.streak + 1;
                if (n.streak == DEB) begin
                    n.mode   = 1;
                    n.streak = 0;
                    n.ev     = 1;
                    n.evts   = (c.evts < 255) ? c.evts + 1 : 255;
                    n.runmax = d;
                end
            end else if (v) begin
                n.streak = 0;
            end
        end else if (c.mode == 1) begin
            if (v) begin
                n.runmax = (d > c.runmax) ? d : c.runmax;
                if (d <= lo) begin
                    n.mode      = 2;
                    n.hold_left = HOLD;
`ifdef PEAK_CAPTURE_EN
                    n.peak = n.runmax;
                    n.pv   = 1;
`endif
                end
            end
        end else begin
            n.hold_left = c.hold_left - 1;
            if (n.hold_left == 0) begin
                n.mode   = 0;
                n.streak = 0;
            end
        end
        n.act = (n.mode == 1) ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst, valid, int'(data), int'(thr_hi), int'(thr_lo));
    end

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_event", o_event, m.ev);
            chk("m_active", o_active, m.act);
            chk("m_evt_cnt", o_evt_cnt, m.evts);
            chk("m_peak", o_peak, m.peak);
            chk("m_peak_valid", o_peak_valid, m.pv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int d);
        valid = 1'b1;
        data  = DW'(d);
        tick();
    endtask

    task automatic idle(int n);
        valid = 1'b0;
        data  = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_peak(int p);
`ifdef PEAK_CAPTURE_EN
        chk("lit_peak", o_peak, p);
        chk("lit_peak_valid", o_peak_valid, 1);
`else
        chk("lit_peak_off", o_peak, 0);
        chk("lit_peak_valid_off", o_peak_valid, 0);
`endif
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        data   = '0;
        thr_hi = 16'sd100;
        thr_lo = 16'sd50;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_active", o_active, 0);
        chk("rst_cnt", o_evt_cnt, 0);
        chk("rst_peak", o_peak, 0);
        rst = 1'b0;

        // Basic trigger
        send(120); send(130);
        chk("pre_event", o_event, 0);
        send(140);
        chk("trig_event", o_event, 1);
        chk("trig_active", o_active, 1);
        chk("trig_cnt", o_evt_cnt, 1);
        idle(1);
        chk("event_one_cycle", o_event, 0);
        send(40);
        chk("release_active", o_active, 0);
        expect_peak(140);
        idle(HOLD);

        // Debounce restart
        send(120); send(130); send(90); send(120); send(130);
        chk("restart_no_event", o_active, 0);
        chk("restart_cnt", o_evt_cnt, 1);
        send(140);
        chk("restart_event", o_event, 1);
        chk("restart_cnt2", o_evt_cnt, 2);

        // Peak and holdoff immunity
        send(200); send(300); send(40);
        chk("peak_release", o_active, 0);
        expect_peak(300);
        for (int i = 0; i < HOLD; i++) send(500);
        chk("holdoff_ignored", o_evt_cnt, 2);
        send(500); send(500); send(500);
        chk("post_hold_event", o_event, 1);
        chk("post_hold_cnt", o_evt_cnt, 3);
        send(10);
        idle(HOLD);

        // Invalid gaps hold the streak
        send(120); idle(2); send(130); idle(2); send(140);
        chk("gap_event", o_event, 1);
        chk("gap_cnt", o_evt_cnt, 4);
        send(0);
        idle(HOLD);

        // Reset mid-ACTIVE
        send(120); send(130); send(140); send(200);
        chk("pre_rst_active", o_active, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_active", o_active, 0);
        chk("mid_rst_event", o_event, 0);
        chk("mid_rst_cnt", o_evt_cnt, 0);
        chk("mid_rst_peak", o_peak, 0);
        chk("mid_rst_pv", o_peak_valid, 0);
        idle(2);

        // Overlapping thresholds: first sample <= lo releases
        thr_lo = 16'sd150;
        send(120); send(120); send(120);
        chk("ovl_event", o_event, 1);
        send(120);
        chk("ovl_release", o_active, 0);
        expect_peak(120);
        idle(HOLD);

        // Signed comparisons
        thr_hi = -16'sd10;
        thr_lo = -16'sd50;
        send(5); send(5); send(5);
        chk("signed_event", o_event, 1);
        send(-20);
        chk("signed_hold_active", o_active, 1);
        send(-60);
        chk("signed_release", o_active, 0);
        expect_peak(5);
        idle(HOLD);

        // Saturation
        thr_hi = 16'sd100;
        thr_lo = 16'sd50;
        for (int k = 0; k < 260; k++) begin
            send(120); send(120); send(120);
            send(0);
            idle(HOLD);
        end
        chk("sat_cnt", o_evt_cnt, 255);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/threshold_detector.md
THRESHOLD_DETECTOR -- requirements
Module: threshold_detector

Interface
REQ-001 The block SHALL have parameter DATA_WD, default 16, sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, range 1..15, count of consecutive valid samples at or above i_thr_hi needed to trigger.
REQ-003 The block SHALL have parameter HOLDOFF, default 8, range 1..255, count of clock cycles spent in HOLDOFF.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the ports are listed next.
REQ-005 i_clk  input  1  clock; all state updates on the rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  i_data qualifier; the upstream filter produces one output per cycle, so i_valid is tied high when driven by the filter.
REQ-008 i_data  input  DATA_WD signed  filtered sample.
REQ-009 i_thr_hi  input  DATA_WD signed  trigger threshold.
REQ-010 i_thr_lo  input  DATA_WD signed  release threshold (hysteresis).
REQ-011 o_event  output  1  single-cycle pulse on entry to ACTIVE.
REQ-012 o_active  output  1  high while in ACTIVE.
REQ-013 o_evt_cnt  output  8  number of events, saturating.
REQ-014 o_peak  output  DATA_WD signed  maximum sample of the last completed ACTIVE interval.
REQ-015 o_peak_valid  output  1  single-cycle pulse when o_peak updates.

Function
REQ-016 The block SHALL implement FSM states IDLE, ACTIVE, HOLDOFF; reset state IDLE.
REQ-017 Comparisons SHALL be signed, full DATA_WD; no truncation.
REQ-018 IDLE: a debounce counter SHALL increment on each valid sample >= i_thr_hi, clear on a valid sample < i_thr_hi, and hold when i_valid=0.
REQ-019 IDLE: on the DEBOUNCE-th consecutive qualifying valid sample, the FSM SHALL enter ACTIVE, clear the debounce counter, and assert o_event and o_active on the next cycle (one-cycle registered latency).
REQ-020 ACTIVE: on a valid sample <= i_thr_lo, the FSM SHALL enter HOLDOFF and deassert o_active the next cycle; otherwise it SHALL remain in ACTIVE.
REQ-021 HOLDOFF: the FSM SHALL remain exactly HOLDOFF cycles, ignoring all inputs, then return to IDLE with a cleared debounce counter.
REQ-022 o_evt_cnt SHALL increment by one with each o_event and saturate at 255.
REQ-023 If i_thr_lo >= i_thr_hi, the behaviour SHALL remain as above, with ACTIVE exiting on the first valid sample <= i_thr_lo.
REQ-024 Threshold inputs SHALL be sampled live on each valid sample; no internal copy.

Reset
REQ-025 Under i_rst=1 at a rising edge, the state SHALL go to IDLE and all counters SHALL clear.
REQ-026 Under reset, the outputs SHALL be: o_event=0, o_active=0, o_evt_cnt=0, o_peak=0, o_peak_valid=0.
REQ-027 Reset SHALL take priority over every state transition, including mid-ACTIVE and mid-HOLDOFF; no o_peak_valid pulse SHALL be produced by reset.

Configuration
REQ-028 With macro PEAK_CAPTURE_EN defined, the block SHALL track the running maximum during ACTIVE, seeded with the triggering sample and updated by each valid sample in ACTIVE, including the releasing sample.
REQ-029 With PEAK_CAPTURE_EN defined, o_peak SHALL load the running maximum and o_peak_valid SHALL pulse on the cycle o_active falls.
REQ-030 Without PEAK_CAPTURE_EN, o_peak SHALL be constant 0, o_peak_valid constant 0, and no peak register SHALL be synthesized.

Verification (DATA_WD=16, DEBOUNCE=3, HOLDOFF=4, i_thr_hi=100, i_thr_lo=50, PEAK_CAPTURE_EN defined unless noted)
REQ-031 Valid samples 120,130,140 -> o_event pulses one cycle after 140 is clocked, o_active=1, o_evt_cnt=1.
REQ-032 Valid samples 120,130,90,120,130 -> no event; debounce restarts after 90, so a further 140 triggers the event.
REQ-033 Valid samples 120,130,140 with i_valid=0 gaps of 2 cycles between them -> the event still fires after 140.
REQ-034 In ACTIVE, samples 200,300,40 -> o_active falls, o_peak=300 with a one-cycle o_peak_valid; then a 500,500,500 burst during the 4 HOLDOFF cycles -> no event; after IDLE, 500x3 -> event.
REQ-035 Trigger the detector, then assert i_rst for 1 cycle mid-ACTIVE -> next cycle all outputs 0, IDLE, and no o_peak_valid pulse.
REQ-036 260 complete events -> o_evt_cnt=255; with PEAK_CAPTURE_EN undefined, o_peak and o_peak_valid stay 0 throughout.
